rf_writeback_queue: RTL and testbench

- Producer-side driver for the 32x32 register file write port.
- Accepts writeback requests (register, data) from the execute/memory stages over a valid/ready handshake.
- Buffers requests in order and drains at most one per cycle onto the register file's write port (WriteReg/WriteData/RegWrite).
- Reports, combinationally, whether a queried read register still has a pending write, so the decode stage can stall.

---
 rtl/rf_pkg.sv | 15 +
 rtl/rf_writeback_queue_if.sv | 29 ++
 rtl/rf_wb_fifo.sv | 63 ++++++
 rtl/rf_writeback_queue.sv | 128 ++++++++++++
 tb/tb_rf_writeback_queue.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/rf_pkg.sv
// Shared register-file constants and the writeback request record used by the
// writeback queue and the blocks that talk to it.
package rf_pkg;

    localparam int RF_ADDR_W   = 5;
    localparam int RF_DATA_W   = 32;
    localparam int RF_NUM_REGS = 32;
    localparam logic [RF_ADDR_W-1:0] RF_ZERO_REG = '0;

    typedef struct packed {
        logic [RF_ADDR_W-1:0] addr;
        logic [RF_DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/rf_writeback_queue_if.sv
// Writeback request channel from the execute/memory stages into the queue.
interface rf_writeback_queue_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) ();

    // A transfer happens on a rising edge where wb_valid && wb_ready. The
    // producer holds wb_reg/wb_data stable while wb_valid is high and unaccepted;
    // wb_ready never depends on wb_valid.
    logic              wb_valid;
    logic              wb_ready;
    logic [ADDR_W-1:0] wb_reg;
    logic [DATA_W-1:0] wb_data;

    modport master (
        output wb_valid,
        output wb_reg,
        output wb_data,
        input  wb_ready
    );

    modport slave (
        input  wb_valid,
        input  wb_reg,
        input  wb_data,
        output wb_ready
    );

endinterface

// File: rtl/rf_wb_fifo.sv
// Generic synchronous FIFO with an age-ordered view of its contents
// (view index 0 is the head) for associative match logic.
module rf_wb_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push_valid,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic [WIDTH-1:0]         view_data [DEPTH],
    output logic                     view_valid [DEPTH]
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign do_push = push_valid && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: occupancy is tracked solely by count_q.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            view_data[k]  = mem[rd_ptr + PW'(k)];
            view_valid[k] = (CW'(k) < count_q);
        end
    end

endmodule

// File: rtl/rf_writeback_queue.sv
// In-order writeback queue driving the register file write port, with
// combinational pending-write hazard flags. Define RF_WB_FORWARD_EN to add fwd_data1/2.
module rf_writeback_queue
    import rf_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int DATA_W = RF_DATA_W,
    parameter int ADDR_W = RF_ADDR_W
) (
    input  logic                   clk,
    input  logic                   reset,
    rf_writeback_queue_if.slave    wb,
    input  logic                   rf_hold,
    output logic [ADDR_W-1:0]      rf_write_reg,
    output logic [DATA_W-1:0]      rf_write_data,
    output logic                   rf_reg_write,
    input  logic [ADDR_W-1:0]      query_reg1,
    input  logic [ADDR_W-1:0]      query_reg2,
    output logic                   hazard1,
    output logic                   hazard2,
    output logic [$clog2(DEPTH):0] count
`ifdef RF_WB_FORWARD_EN
    ,
    output logic [DATA_W-1:0]      fwd_data1,
    output logic [DATA_W-1:0]      fwd_data2
`endif
);

    localparam int EW = ADDR_W + DATA_W;
    localparam logic [ADDR_W-1:0] ZERO = ADDR_W'(RF_ZERO_REG);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } entry_t;

    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_push;
    logic             fifo_pop;
    logic [EW-1:0]    view_data [DEPTH];
    logic             view_valid [DEPTH];
    entry_t           head;

    // r0 writes still complete the handshake but are never stored.
    assign wb.wb_ready = !fifo_full;
    assign fifo_push   = wb.wb_valid && (wb.wb_reg != ZERO);
    assign fifo_pop    = !fifo_empty && !rf_hold;
    assign head        = entry_t'(view_data[0]);

    rf_wb_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push_valid (fifo_push),
        .push_data  ({wb.wb_reg, wb.wb_data}),
        .pop        (fifo_pop),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .count      (count),
        .view_data  (view_data),
        .view_valid (view_valid)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            rf_reg_write  <= 1'b0;
            rf_write_reg  <= '0;
            rf_write_data <= '0;
        end else if (fifo_pop) begin
            rf_reg_write  <= 1'b1;
            rf_write_reg  <= head.addr;
            rf_write_data <= head.data;
        end else begin
            rf_reg_write  <= 1'b0;
        end
    end

    logic [ADDR_W-1:0] query [2];
    logic              hit [2];

    assign query[0] = query_reg1;
    assign query[1] = query_reg2;
    assign hazard1  = hit[0];
    assign hazard2  = hit[1];

`ifdef RF_WB_FORWARD_EN
    logic [DATA_W-1:0] fwd [2];

    assign fwd_data1 = fwd[0];
    assign fwd_data2 = fwd[1];

    // Output stage is the oldest candidate; later (younger) queue matches overwrite it.
    always_comb begin
        for (int n = 0; n < 2; n++) begin
            hit[n] = 1'b0;
            fwd[n] = '0;
            if (query[n] != ZERO) begin
                if (rf_reg_write && (rf_write_reg == query[n])) begin
                    hit[n] = 1'b1;
                    fwd[n] = rf_write_data;
                end
                for (int k = 0; k < DEPTH; k++) begin
                    if (view_valid[k] && (view_data[k][EW-1 -: ADDR_W] == query[n])) begin
                        hit[n] = 1'b1;
                        fwd[n] = view_data[k][DATA_W-1:0];
                    end
                end
            end
        end
    end
`else
    always_comb begin
        for (int n = 0; n < 2; n++) begin
            hit[n] = 1'b0;
            if (query[n] != ZERO) begin
                if (rf_reg_write && (rf_write_reg == query[n])) hit[n] = 1'b1;
                for (int k = 0; k < DEPTH; k++) begin
                    if (view_valid[k] && (view_data[k][EW-1 -: ADDR_W] == query[n])) hit[n] = 1'b1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_rf_writeback_queue.sv
// Self-checking bench for rf_writeback_queue: directed scenarios plus random
// traffic compared each cycle against a queue-based reference model.
module tb_rf_writeback_queue;
    import rf_pkg::*;

    localparam int DEPTH = 4;

    logic        clk;
    logic        reset;
    logic        rf_hold;
    logic [4:0]  rf_write_reg;
    logic [31:0] rf_write_data;
    logic        rf_reg_write;
    logic [4:0]  query_reg1;
    logic [4:0]  query_reg2;
    logic        hazard1;
    logic        hazard2;
    logic [2:0]  count;
`ifdef RF_WB_FORWARD_EN
    logic [31:0] fwd_data1;
    logic [31:0] fwd_data2;
`endif

    rf_writeback_queue_if #(.ADDR_W(5), .DATA_W(32)) wbif ();

    rf_writeback_queue #(.DEPTH(DEPTH)) dut (
        .clk           (clk),
        .reset         (reset),
        .wb            (wbif),
        .rf_hold       (rf_hold),
        .rf_write_reg  (rf_write_reg),
        .rf_write_data (rf_write_data),
        .rf_reg_write  (rf_reg_write),
        .query_reg1    (query_reg1),
        .query_reg2    (query_reg2),
        .hazard1       (hazard1),
        .hazard2       (hazard2),
        .count         (count)
`ifdef RF_WB_FORWARD_EN
        ,
        .fwd_data1     (fwd_data1),
        .fwd_data2     (fwd_data2)
`endif
    );

    // Clock and reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: pending entries oldest-first, plus the output stage.
    wb_entry_t   mq[$];
    bit          out_v;
    logic [4:0]  out_r;
    logic [31:0] out_d;

    // Scoreboard: every accepted non-r0 request must appear on the write port in order.
    logic [36:0] exp_q[$];

    int errors;
    int checks;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic bit model_hazard(input logic [4:0] q);
        if (q == 5'd0) return 1'b0;
        if (out_v && out_r == q) return 1'b1;
        foreach (mq[i]) if (mq[i].addr == q) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] model_fwd(input logic [4:0] q);
        if (q == 5'd0) return 32'd0;
        for (int i = mq.size() - 1; i >= 0; i--) if (mq[i].addr == q) return mq[i].data;
        if (out_v && out_r == q) return out_d;
        return 32'd0;
    endfunction

    task automatic model_edge(input logic v, input logic [4:0] r, input logic [31:0] d,
                              input logic h, input logic rst);
        wb_entry_t e;
        bit        rdy;
        if (rst) begin
            mq.delete();
            exp_q.delete();
            out_v = 1'b0;
            out_r = '0;
            out_d = '0;
        end else begin
            rdy = (mq.size() < DEPTH);
            if (mq.size() > 0 && !h) begin
                e     = mq.pop_front();
                out_v = 1'b1;
                out_r = e.addr;
                out_d = e.data;
            end else begin
                out_v = 1'b0;
            end
            if (v && rdy && r != 5'd0) begin
                mq.push_back('{addr: r, data: d});
                exp_q.push_back({r, d});
            end
        end
    endtask

    // Driver: one clock cycle, entered and left at a falling edge.
    task automatic step(input logic v, input logic [4:0] r, input logic [31:0] d,
                        input logic h, input logic [4:0] q1, input logic [4:0] q2,
                        input logic rst);
        logic [36:0] got;
        wbif.wb_valid = v;
        wbif.wb_reg   = r;
        wbif.wb_data  = d;
        rf_hold       = h;
        query_reg1    = q1;
        query_reg2    = q2;
        reset         = rst;
        #1;
        check("wb_ready", wbif.wb_ready, (mq.size() < DEPTH));
        check("hazard1", hazard1, model_hazard(q1));
        check("hazard2", hazard2, model_hazard(q2));
`ifdef RF_WB_FORWARD_EN
        check("fwd_data1", fwd_data1, model_fwd(q1));
        check("fwd_data2", fwd_data2, model_fwd(q2));
`endif
        @(posedge clk);
        model_edge(v, r, d, h, rst);
        @(negedge clk);
        check("rf_reg_write", rf_reg_write, out_v);
        check("rf_write_reg", rf_write_reg, out_r);
        check("rf_write_data", rf_write_data, out_d);
        check("count", count, mq.size());
        if (rf_reg_write === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_write", 1, 0);
            end else begin
                got = {rf_write_reg, rf_write_data};
                check("sb_order", got, exp_q.pop_front());
            end
        end
    endtask

    task automatic idle(input logic h, input logic [4:0] q1, input logic [4:0] q2);
        step(1'b0, 5'd0, 32'd0, h, q1, q2, 1'b0);
    endtask

    int exp_regs[5] = '{1, 2, 3, 4, 5};

    initial begin
        errors = 0;
        checks = 0;
        out_v  = 1'b0;
        out_r  = '0;
        out_d  = '0;
        wbif.wb_valid = 1'b0;
        wbif.wb_reg   = '0;
        wbif.wb_data  = '0;
        rf_hold       = 1'b0;
        query_reg1    = '0;
        query_reg2    = '0;
        reset         = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        check("reset_count", count, 0);
        check("reset_ready", wbif.wb_ready, 1);
        check("reset_reg_write", rf_reg_write, 0);
        check("reset_write_reg", rf_write_reg, 0);
        check("reset_write_data", rf_write_data, 0);
        check("reset_hazard1", hazard1, 0);

        // Single request through to the write port
        step(1'b1, 5'd16, 32'hAAAA_FFFF, 1'b0, 5'd0, 5'd0, 1'b0);
        check("t1_count_after_push", count, 1);
        idle(1'b0, 5'd0, 5'd0);
        check("t1_reg_write", rf_reg_write, 1);
        check("t1_write_reg", rf_write_reg, 16);
        check("t1_write_data", rf_write_data, 32'hAAAA_FFFF);
        check("t1_count_drained", count, 0);
        idle(1'b0, 5'd0, 5'd0);
        check("t1_reg_write_drop", rf_reg_write, 0);

        // r0 write is acknowledged and discarded
        step(1'b1, 5'd0, 32'h1234_5678, 1'b0, 5'd0, 5'd0, 1'b0);
        check("t2_ready", wbif.wb_ready, 1);
        check("t2_count", count, 0);
        check("t2_hazard1_r0", hazard1, 0);
        idle(1'b0, 5'd0, 5'd0);
        check("t2_no_write", rf_reg_write, 0);

        // Fill under rf_hold, then drain in order with reg 5 retried
        for (int i = 1; i <= 4; i++) step(1'b1, 5'(i), 32'h100 + 32'(i), 1'b1, 5'd0, 5'd0, 1'b0);
        check("t3_full_ready", wbif.wb_ready, 0);
        check("t3_full_count", count, 4);
        step(1'b1, 5'd5, 32'h105, 1'b1, 5'd0, 5'd0, 1'b0);
        check("t3_still_full", count, 4);
        for (int i = 0; i < 5; i++) begin
            if (i < 2) step(1'b1, 5'd5, 32'h105, 1'b0, 5'd0, 5'd0, 1'b0);
            else       idle(1'b0, 5'd0, 5'd0);
            check("t3_drain_we", rf_reg_write, 1);
            check("t3_drain_reg", rf_write_reg, 5'(exp_regs[i]));
        end
        idle(1'b0, 5'd0, 5'd0);

        // Hazard detection through queue and output stage
        step(1'b1, 5'd8, 32'h8, 1'b1, 5'd0, 5'd0, 1'b0);
        step(1'b1, 5'd9, 32'h9, 1'b1, 5'd0, 5'd0, 1'b0);
        idle(1'b1, 5'd9, 5'd10);
        check("t4_hazard1_q", hazard1, 1);
        check("t4_hazard2_none", hazard2, 0);
        idle(1'b0, 5'd9, 5'd10);
        idle(1'b0, 5'd9, 5'd10);
        check("t4_hazard1_out", hazard1, 1);
        idle(1'b0, 5'd9, 5'd10);
        check("t4_hazard1_clear", hazard1, 0);

        // Reset with entries queued
        for (int i = 0; i < 3; i++) step(1'b1, 5'(11 + i), 32'(i), 1'b1, 5'd0, 5'd0, 1'b0);
        check("t5_count_before", count, 3);
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 5'd0, 1'b1);
        check("t5_count", count, 0);
        check("t5_reg_write", rf_reg_write, 0);
        check("t5_ready", wbif.wb_ready, 1);
        idle(1'b0, 5'd12, 5'd0);
        check("t5_no_write", rf_reg_write, 0);
        check("t5_no_hazard", hazard1, 0);

`ifdef RF_WB_FORWARD_EN
        step(1'b1, 5'd7, 32'h1, 1'b1, 5'd0, 5'd0, 1'b0);
        step(1'b1, 5'd7, 32'h2, 1'b1, 5'd0, 5'd0, 1'b0);
        idle(1'b1, 5'd7, 5'd0);
        check("t6_hazard1", hazard1, 1);
        check("t6_fwd1_youngest", fwd_data1, 32'h2);
        repeat (4) idle(1'b0, 5'd7, 5'd0);
`endif

        // Random traffic
        for (int c = 0; c < 800; c++) begin
            step($urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), $urandom,
                 $urandom_range(0, 3) == 0, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                 $urandom_range(0, 149) == 0);
        end
        repeat (DEPTH + 3) idle(1'b0, 5'd0, 5'd0);
        check("final_count", count, 0);
        check("final_sb_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
